prog_mem_rw: RTL and testbench
==============================

# prog_mem_rw

Parametrised, writable successor to the fixed-content program memory: a single-port-write / single-port-read instruction store with a registered fetch port, a programming port for loading code at run time, and a hardware clear sequencer that fills every word with a NOP. Sits between the instruction-address counter (fetch side) and the test/loader logic (programming side) of the lab CPU. Replaces hard-coded `initial` contents with a reset-driven, synthesizable initialisation.

## Interface
Parameters:
- INSTRUCTION_WIDTH, 16, bits per instruction word (≥ 4)
- BITS_FOR_INSTRUCTIONS, 5, address width
- NUMBER_OF_INSTRUCTIONS, 32, implemented depth; 1 ≤ N ≤ 2^BITS_FOR_INSTRUCTIONS
- NOP_WORD, 16'h000F, fill value (opcode NOP = 4'b1111 in bits [3:0], rest zero)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- clear_req  in  1  start NOP-fill of whole memory
- busy  out  1  high while clear sequence runs
- prog_we  in  1  write request
- prog_addr  in  BITS_FOR_INSTRUCTIONS  write address
- prog_data  in  INSTRUCTION_WIDTH  write data
- prog_ack  out  1  one-cycle pulse: write committed
- fetch_req  in  1  read request
- fetch_addr  in  BITS_FOR_INSTRUCTIONS  read address
- instr  out  INSTRUCTION_WIDTH  fetched instruction (registered)
- instr_valid  out  1  one-cycle pulse: instr updated by a fetch
- addr_err  out  1  one-cycle pulse: out-of-range fetch or write

## Operation
- States: CLEAR, RUN.
- CLEAR: internal pointer clr_ptr writes NOP_WORD to mem[clr_ptr], clr_ptr increments 0 → N-1, one word per cycle; after writing N-1 → RUN. busy = 1 throughout CLEAR.
- In CLEAR: prog_we, fetch_req, clear_req ignored; prog_ack, instr_valid, addr_err stay 0; instr holds.
- RUN, clear_req = 1: → CLEAR with clr_ptr = 0; any prog_we/fetch_req that same cycle ignored.
- RUN, prog_we with prog_addr < N: mem[prog_addr] ← prog_data; prog_ack = 1 next cycle.
- RUN, prog_we with prog_addr ≥ N: write dropped, prog_ack = 0, addr_err = 1 next cycle.
- RUN, fetch_req with fetch_addr < N: instr ← mem[fetch_addr], instr_valid = 1 next cycle.
- RUN, fetch_req with fetch_addr ≥ N: instr ← NOP_WORD, instr_valid = 1, addr_err = 1 next cycle.
- Simultaneous write and fetch, same address: read-first — instr gets the old contents; the new data is visible from the following fetch.
- Simultaneous write and fetch, different addresses: both complete independently.
- addr_err is the OR of write-error and fetch-error in the same cycle.
- No fetch: instr holds its last value; instr_valid = 0.

## Timing
- rst sampled high at edge k: state ← CLEAR, clr_ptr ← 0. After edge k: busy = 1, instr = NOP_WORD, instr_valid = 0, prog_ack = 0, addr_err = 0.
- Clear length: exactly N cycles with busy = 1. First RUN-state request is accepted at edge k+N+1.
- rst during CLEAR restarts the clear from clr_ptr = 0. rst during RUN discards in-flight pulses: the outputs after the edge take their reset values.
- Fetch latency: 1 cycle (request at edge j → instr/instr_valid valid after edge j+1). Back-to-back fetches are supported every cycle.
- Write latency: 1 cycle to prog_ack. Back-to-back writes are supported every cycle.
- clear_req is level-sampled only in RUN. A clear_req held high re-enters CLEAR after each completed fill.

## Test plan
- Reset then idle: rst 1 cycle → busy high for 32 cycles, then 0. Fetches of addresses 0..31 all return 16'h000F with instr_valid each cycle.
- Program/fetch: write 16'h00FE to addr 14 → prog_ack next cycle. A fetch of 14 one cycle later returns 16'h00FE.
- Read-first collision: mem[3] = 16'h0010. Same-cycle write 16'h0040 to 3 and fetch 3 → instr = 16'h0010. The next fetch of 3 → 16'h0040.
- Out of range with N = 20, BITS = 5: write addr 25 → addr_err pulse, no prog_ack, mem unchanged. Fetch 25 → instr = 16'h000F, instr_valid = 1, addr_err = 1.
- Clear mid-run: load addrs 0..9 with 16'h0000 (ADD). Assert clear_req → busy 32 cycles; fetches and writes during busy produce no pulses. Afterwards all addresses read 16'h000F.
- Reset mid-clear: assert rst at clear cycle 10 → busy stays high for a full 32 more cycles, and all words read NOP afterwards.

Source files
------------

// File: rtl/prog_mem_rw.sv
// Writable instruction store for the lab CPU: registered fetch port, programming port,
// and a reset/clear sequencer that fills every word with NOP_WORD.
module prog_mem_rw #(
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int BITS_FOR_INSTRUCTIONS  = 5,
  parameter int NUMBER_OF_INSTRUCTIONS = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD = 16'h000F
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_req,
  output logic                             busy,
  input  logic                             prog_we,
  input  logic [BITS_FOR_INSTRUCTIONS-1:0] prog_addr,
  input  logic [INSTRUCTION_WIDTH-1:0]     prog_data,
  output logic                             prog_ack,
  input  logic                             fetch_req,
  input  logic [BITS_FOR_INSTRUCTIONS-1:0] fetch_addr,
  output logic [INSTRUCTION_WIDTH-1:0]     instr,
  output logic                             instr_valid,
  output logic                             addr_err
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_ADDR =
    BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);
  localparam logic [BITS_FOR_INSTRUCTIONS:0] DEPTH =
    (BITS_FOR_INSTRUCTIONS + 1)'(NUMBER_OF_INSTRUCTIONS);

  logic [INSTRUCTION_WIDTH-1:0]     mem_r [NUMBER_OF_INSTRUCTIONS];
  logic [0:0]                       state_r;
  logic [BITS_FOR_INSTRUCTIONS-1:0] clr_ptr_r;
  logic [INSTRUCTION_WIDTH-1:0]     instr_r;
  logic                             instr_valid_r;
  logic                             prog_ack_r;
  logic                             addr_err_r;

  logic                             prog_in_range_s;
  logic                             fetch_in_range_s;
  logic                             run_accept_s;
  logic                             wr_ok_s;
  logic                             wr_bad_s;
  logic                             rd_bad_s;
  logic                             mem_we_s;
  logic [BITS_FOR_INSTRUCTIONS-1:0] mem_waddr_s;
  logic [INSTRUCTION_WIDTH-1:0]     mem_wdata_s;
  logic [INSTRUCTION_WIDTH-1:0]     rd_data_s;

  // A full power-of-two depth makes every address legal, so skip the compare entirely.
  if (NUMBER_OF_INSTRUCTIONS < (2 ** BITS_FOR_INSTRUCTIONS)) begin : g_partial_depth
    assign prog_in_range_s  = ({1'b0, prog_addr}  < DEPTH);
    assign fetch_in_range_s = ({1'b0, fetch_addr} < DEPTH);
  end else begin : g_full_depth
    assign prog_in_range_s  = 1'b1;
    assign fetch_in_range_s = 1'b1;
  end

  assign run_accept_s = (state_r == RUN) && !clear_req;
  assign wr_ok_s      = run_accept_s && prog_we && prog_in_range_s;
  assign wr_bad_s     = run_accept_s && prog_we && !prog_in_range_s;
  assign rd_bad_s     = run_accept_s && fetch_req && !fetch_in_range_s;

  // Select the single write port source: clear sequencer or programming port
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = clr_ptr_r;
    mem_wdata_s = NOP_WORD;
    if (rst) begin
      mem_we_s = 1'b0;
    end else if (state_r == CLEAR) begin
      mem_we_s = 1'b1;
    end else if (wr_ok_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = prog_addr;
      mem_wdata_s = prog_data;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Out-of-range fetches return NOP rather than touching the array
  always_comb begin
    rd_data_s = NOP_WORD;
    if (fetch_in_range_s) begin
      rd_data_s = mem_r[fetch_addr];
    end else begin
      rd_data_s = NOP_WORD;
    end
  end

  // Storage array; contents are established by the clear sequencer, not by reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Sequencer state, clear pointer and registered fetch/ack/error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= CLEAR;
      clr_ptr_r     <= '0;
      instr_r       <= NOP_WORD;
      instr_valid_r <= 1'b0;
      prog_ack_r    <= 1'b0;
      addr_err_r    <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          instr_valid_r <= 1'b0;
          prog_ack_r    <= 1'b0;
          addr_err_r    <= 1'b0;
          if (clr_ptr_r == LAST_ADDR) begin
            state_r   <= RUN;
            clr_ptr_r <= '0;
          end else begin
            clr_ptr_r <= clr_ptr_r + 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state_r       <= CLEAR;
            clr_ptr_r     <= '0;
            instr_valid_r <= 1'b0;
            prog_ack_r    <= 1'b0;
            addr_err_r    <= 1'b0;
          end else begin
            // Read-first: rd_data_s samples the array before this edge's write lands
            prog_ack_r    <= wr_ok_s;
            addr_err_r    <= wr_bad_s || rd_bad_s;
            instr_valid_r <= fetch_req;
            if (fetch_req) begin
              instr_r <= rd_data_s;
            end
          end
        end
        default: begin
          state_r       <= CLEAR;
          clr_ptr_r     <= '0;
          instr_valid_r <= 1'b0;
          prog_ack_r    <= 1'b0;
          addr_err_r    <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = (state_r == CLEAR);
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign prog_ack    = prog_ack_r;
  assign addr_err    = addr_err_r;

endmodule

// File: tb/tb_prog_mem_rw.sv
// Scoreboard bench for prog_mem_rw: a full-depth instance (N=32) against a cycle model,
// plus a partial-depth instance (N=20) for out-of-range behaviour.
module tb_prog_mem_rw;

  localparam logic [15:0] NOP = 16'h000F;

  logic        clk = 1'b0;
  logic        rst, clear_req, prog_we, fetch_req;
  logic [4:0]  prog_addr, fetch_addr;
  logic [15:0] prog_data;

  logic        busy, prog_ack, instr_valid, addr_err;
  logic [15:0] instr;
  logic        b_busy, b_ack, b_valid, b_err;
  logic [15:0] b_instr;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_mem [32];
  logic        m_busy = 1'b0;
  int          m_ptr = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  prog_mem_rw #(.INSTRUCTION_WIDTH(16), .BITS_FOR_INSTRUCTIONS(5),
                .NUMBER_OF_INSTRUCTIONS(32), .NOP_WORD(16'h000F)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(prog_ack),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .instr(instr),
    .instr_valid(instr_valid), .addr_err(addr_err));

  prog_mem_rw #(.INSTRUCTION_WIDTH(16), .BITS_FOR_INSTRUCTIONS(5),
                .NUMBER_OF_INSTRUCTIONS(20), .NOP_WORD(16'h000F)) dut_short (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(b_busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(b_ack),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .instr(b_instr),
    .instr_valid(b_valid), .addr_err(b_err));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, step the model across the edge, then compare just after it.
  task automatic cycle(input logic r, input logic cr, input logic we, input int pa,
                       input logic [15:0] pd, input logic fr, input int fa);
    logic e_ack, e_err, e_valid;
    logic [15:0] got_exp;
    rst = r; clear_req = cr; prog_we = we; prog_addr = pa[4:0]; prog_data = pd;
    fetch_req = fr; fetch_addr = fa[4:0];
    @(posedge clk);
    e_ack = 1'b0; e_err = 1'b0; e_valid = 1'b0;
    if (r) begin
      m_busy = 1'b1; m_ptr = 0; exp_q.delete();
    end else if (m_busy) begin
      m_mem[m_ptr] = NOP;
      if (m_ptr == 31) begin m_busy = 1'b0; m_ptr = 0; end
      else m_ptr++;
    end else if (cr) begin
      m_busy = 1'b1; m_ptr = 0;
    end else begin
      e_ack = we; e_valid = fr;
      if (fr) exp_q.push_back(m_mem[fa[4:0]]);
      if (we) m_mem[pa[4:0]] = pd;
    end
    #1;
    check_eq("busy", busy, m_busy);
    check_eq("prog_ack", prog_ack, e_ack);
    check_eq("addr_err", addr_err, e_err);
    check_eq("instr_valid", instr_valid, e_valid);
    if (r) check_eq("reset_instr", instr, NOP);
    if (instr_valid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("instr_unexpected", instr_valid, 1'b0);
      else begin
        got_exp = exp_q.pop_front();
        check_eq("instr", instr, got_exp);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 0);
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    cycle(1'b0, 1'b0, 1'b1, a, d, 1'b0, 0);
  endtask

  task automatic rd(input int a);
    cycle(1'b0, 1'b0, 1'b0, 0, 16'h0000, 1'b1, a);
  endtask

  task automatic fetch_all;
    for (int i = 0; i < 32; i++) rd(i);
    idle(1);
  endtask

  initial begin
    // Reset, then a full 32-cycle fill and an all-NOP readback
    cycle(1'b1, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 0);
    idle(32);
    check_eq("busy_after_fill", busy, 1'b0);
    fetch_all();

    // Program then fetch
    wr(14, 16'h00FE);
    idle(1);
    rd(14);
    idle(1);

    // Read-first collision
    wr(3, 16'h0010);
    cycle(1'b0, 1'b0, 1'b1, 3, 16'h0040, 1'b1, 3);
    rd(3);
    idle(1);

    // Out of range on the 20-deep instance
    wr(25, 16'hBEEF);
    check_eq("short_oor_wr_ack", b_ack, 1'b0);
    check_eq("short_oor_wr_err", b_err, 1'b1);
    rd(25);
    check_eq("short_oor_rd_instr", b_instr, NOP);
    check_eq("short_oor_rd_valid", b_valid, 1'b1);
    check_eq("short_oor_rd_err", b_err, 1'b1);
    rd(9);
    check_eq("short_alias_instr", b_instr, NOP);
    check_eq("short_alias_err", b_err, 1'b0);
    wr(5, 16'h1234);
    check_eq("short_wr_ack", b_ack, 1'b1);
    rd(5);
    check_eq("short_rd_instr", b_instr, 16'h1234);
    check_eq("short_rd_valid", b_valid, 1'b1);
    idle(1);

    // Random back-to-back traffic, biased towards same-address collisions
    for (int i = 0; i < 60; i++) begin
      int a1, a2;
      a1 = int'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : int'($urandom_range(0, 31));
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), a1, 16'($urandom),
            1'($urandom_range(0, 1)), a2);
    end
    idle(1);

    // Clear mid-run, with requests during busy that must be ignored
    for (int i = 0; i < 10; i++) wr(i, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 0);
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 1'b0, 1'b1, i, 16'h5555, 1'b1, 31 - i);
    fetch_all();

    // Reset in the middle of a clear restarts the full fill
    for (int i = 20; i < 24; i++) wr(i, 16'hAAAA);
    cycle(1'b0, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 0);
    idle(10);
    cycle(1'b1, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 0);
    idle(32);
    fetch_all();

    // clear_req held high re-enters CLEAR after each completed fill
    wr(7, 16'h0123);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b1, 7, 16'h7777, 1'b1, 7);
    idle(40);
    fetch_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
